// File: rtl/mux_rr_pipe_pkg.sv
// mux_pkg: constants shared by all mux variants.
//   MODE_SEL : fixed channel select taken from the sel input
//   MODE_RR  : round-robin auto-select among valid channels
package mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

endpackage : mux_pkg

// File: rtl/mux_rr_pipe_if.sv
// mux_rr_pipe_if: handshake/data bundle between N producers, the mux and one consumer.
//   in_data   N*W  channel k data at [k*W +: W]
//   in_valid  N    per-channel valid
//   in_ready  N    per-channel ready (one-hot or zero)
//   out_data  W    registered selected word
//   out_chan  SELW index of channel that supplied out_data
//   out_valid 1    output slot holds a word
//   out_ready 1    consumer accepts the word
//   out_par   1    parity of out_data (only when MUX_PARITY_EN is defined)
// Modports: slave = the mux, master = producers/consumer side.
interface mux_rr_pipe_if #(
  parameter int W = 8,
  parameter int N = 4
);
  localparam int SELW = $clog2(N);

  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_chan;
  logic            out_valid;
  logic            out_ready;
`ifdef MUX_PARITY_EN
  logic            out_par;
`endif

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_chan, out_valid
`ifdef MUX_PARITY_EN
    , output out_par
`endif
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_chan, out_valid
`ifdef MUX_PARITY_EN
    , input out_par
`endif
  );

endinterface : mux_rr_pipe_if

// File: rtl/mux_rr_pipe_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant.
//   req[N]        request vector
//   ptr[SELW]     highest-priority index for this cycle
//   gnt_valid     at least one request present
//   gnt_idx[SELW] first requesting index found searching ptr, ptr+1, ... mod N
// N must be a power of two so index arithmetic wraps in SELW bits.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_idx
);
  localparam int SELW = $clog2(N);

  // Request vector rotated so that bit 0 corresponds to ptr.
  logic [N-1:0]    rot;
  logic [SELW-1:0] off;
  logic            found;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
      assign rot[gi] = req[ptr + SELW'(gi)];
    end
  endgenerate

  // Lowest set bit of the rotated vector wins; scanning downward lets the
  // last hit (smallest offset) stick.
  always_comb begin
    off   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = SELW'(i);
      end
    end
  end

  assign gnt_valid = found;
  assign gnt_idx   = ptr + off;

endmodule : rr_arbiter

// File: rtl/mux_rr_pipe.sv
// mux_rr_pipe: N-channel, W-bit registered mux with valid/ready handshake.
//   clk   system clock (rising edge)
//   rst   synchronous active-high reset
//   mode  0 = fixed select (sel), 1 = round-robin
//   sel   channel index used in fixed mode
//   bus   mux_rr_pipe_if.slave: input channels and output slot
// Optional feature: define MUX_PARITY_EN to add bus.out_par, the registered
// even-parity of the selected word.
module mux_rr_pipe
  import mux_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [$clog2(N)-1:0] sel,
  mux_rr_pipe_if.slave         bus
);
  localparam int SELW = $clog2(N);

  logic [W-1:0]    chan_data [N];
  logic            rr_valid;
  logic [SELW-1:0] rr_idx;
  logic            gnt_valid;
  logic [SELW-1:0] gnt_idx;
  logic            slot_free;
  logic            accept;
  logic            xfer;

  logic [W-1:0]    out_data_reg,  out_data_next;
  logic [SELW-1:0] out_chan_reg,  out_chan_next;
  logic            out_valid_reg, out_valid_next;
  logic [SELW-1:0] ptr_reg,       ptr_next;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_split
      assign chan_data[gi] = bus.in_data[gi*W +: W];
    end
  endgenerate

  rr_arbiter #(.N(N)) u_arb (
    .req       (bus.in_valid),
    .ptr       (ptr_reg),
    .gnt_valid (rr_valid),
    .gnt_idx   (rr_idx)
  );

  always_comb begin
    gnt_valid = rr_valid;
    gnt_idx   = rr_idx;
    if (mode == MODE_SEL) begin
      gnt_valid = 1'b1;
      gnt_idx   = sel;
    end
  end

  // The slot can take a word when empty or when the held word leaves this cycle.
  assign slot_free = !out_valid_reg || bus.out_ready;
  assign accept    = !rst && gnt_valid && slot_free;
  assign xfer      = accept && bus.in_valid[gnt_idx];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ready
      assign bus.in_ready[gi] = accept && (gnt_idx == SELW'(gi));
    end
  endgenerate

  always_comb begin
    out_data_next  = out_data_reg;
    out_chan_next  = out_chan_reg;
    out_valid_next = out_valid_reg;
    ptr_next       = ptr_reg;
    if (xfer) begin
      out_data_next  = chan_data[gnt_idx];
      out_chan_next  = gnt_idx;
      out_valid_next = 1'b1;
      if (mode == MODE_RR) begin
        ptr_next = gnt_idx + SELW'(1);  // wraps N-1 -> 0
      end
    end else if (bus.out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_reg  <= '0;
      out_chan_reg  <= '0;
      out_valid_reg <= 1'b0;
      ptr_reg       <= '0;
    end else begin
      out_data_reg  <= out_data_next;
      out_chan_reg  <= out_chan_next;
      out_valid_reg <= out_valid_next;
      ptr_reg       <= ptr_next;
    end
  end

  assign bus.out_data  = out_data_reg;
  assign bus.out_chan  = out_chan_reg;
  assign bus.out_valid = out_valid_reg;

`ifdef MUX_PARITY_EN
  logic par_reg, par_next;

  always_comb begin
    par_next = par_reg;
    if (xfer) begin
      par_next = ^chan_data[gnt_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      par_reg <= 1'b0;
    end else begin
      par_reg <= par_next;
    end
  end

  assign bus.out_par = par_reg;
`endif

endmodule : mux_rr_pipe

// File: tb/tb_mux_rr_pipe.sv
// tb_mux_rr_pipe: directed test of mux_rr_pipe (W=8, N=4). The driver pushes
// hand-computed expected words into a scoreboard; a monitor pops and compares
// whenever the consumer takes a word.
module tb_mux_rr_pipe;
  import mux_pkg::*;

  localparam int W = 8;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic [1:0] sel;

  mux_rr_pipe_if #(.W(W), .N(N)) bus ();

  mux_rr_pipe #(.W(W), .N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .sel  (sel),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [1:0] c;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic set_ch(input int k, input logic [7:0] v);
    bus.in_data[k*8 +: 8] = v;
  endtask

  // Monitor: a word leaves when out_valid && out_ready at the coming edge.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", {22'd0, bus.out_chan, bus.out_data}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", {24'd0, bus.out_data}, {24'd0, e.d});
        chk("out_chan", {30'd0, bus.out_chan}, {30'd0, e.c});
`ifdef MUX_PARITY_EN
        chk("out_par", {31'd0, bus.out_par}, {31'd0, ^e.d});
`endif
        $display("word data=%02h chan=%0d", bus.out_data, bus.out_chan);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    mode = MODE_SEL;
    sel = 2'd2;
    bus.in_data = '0;
    bus.in_valid = 4'b1111;
    bus.out_ready = 1'b0;

    // 1: reset state
    tick(); tick();
    settle();
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, bus.out_data}, 32'd0);
    chk("rst_out_chan", {30'd0, bus.out_chan}, 32'd0);
    chk("rst_in_ready", {28'd0, bus.in_ready}, 32'd0);
    tick();
    rst = 1'b0; bus.in_valid = 4'b0000;
    settle();
    chk("sel2_in_ready", {28'd0, bus.in_ready}, 32'h4);

    // 2: fixed select of ch2
    tick();
    bus.in_valid = 4'b0100; set_ch(2, 8'hA5); bus.out_ready = 1'b1;
    sb.push_back('{d: 8'hA5, c: 2'd2});
    settle();
    chk("t2_in_ready", {28'd0, bus.in_ready}, 32'h4);
    tick();
    bus.out_ready = 1'b0;
    settle();
    chk("t2_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("t2_out_data", {24'd0, bus.out_data}, 32'hA5);
    chk("t2_out_chan", {30'd0, bus.out_chan}, 32'd2);

    // 3: backpressure, then release with no bubble
    for (int i = 0; i < 3; i++) begin
      tick();
      set_ch(2, 8'h30 + 8'(i));
      settle();
      chk("bp_out_data", {24'd0, bus.out_data}, 32'hA5);
      chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_in_ready", {28'd0, bus.in_ready}, 32'd0);
    end
    tick();
    bus.out_ready = 1'b1; set_ch(2, 8'h5A);
    sb.push_back('{d: 8'h5A, c: 2'd2});
    settle();
    chk("rel_in_ready", {28'd0, bus.in_ready}, 32'h4);
    tick();
    bus.in_valid = 4'b0000;
    settle();
    chk("nogap_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("nogap_out_data", {24'd0, bus.out_data}, 32'h5A);
    tick();
    settle();
    chk("drain_out_valid", {31'd0, bus.out_valid}, 32'd0);

    // 4: round-robin over all four channels
    tick();
    mode = MODE_RR;
    for (int k = 0; k < 4; k++) set_ch(k, 8'h10 + 8'(k));
    bus.in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      logic [1:0] c;
      c = 2'(i);
      sb.push_back('{d: 8'h10 + 8'(c), c: c});
      settle();
      chk("rr_in_ready", {28'd0, bus.in_ready}, 32'd1 << c);
      tick();
    end

    // 5: ptr=1 with only ch3/ch0 requesting -> 3 then 0
    bus.in_valid = 4'b1001;
    sb.push_back('{d: 8'h13, c: 2'd3});
    settle();
    chk("wrap_in_ready3", {28'd0, bus.in_ready}, 32'h8);
    tick();
    sb.push_back('{d: 8'h10, c: 2'd0});
    settle();
    chk("wrap_in_ready0", {28'd0, bus.in_ready}, 32'h1);
    tick();
    bus.in_valid = 4'b0000;
    settle();
    chk("wrap_last_chan", {30'd0, bus.out_chan}, 32'd0);

    // 6: hold a word with ptr=2, reset drops it and ptr returns to 0
    tick();
    bus.in_valid = 4'b0010;
    settle();
    chk("pre_in_ready", {28'd0, bus.in_ready}, 32'h2);
    tick();
    bus.in_valid = 4'b0000; bus.out_ready = 1'b0;
    settle();
    chk("held_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("held_out_data", {24'd0, bus.out_data}, 32'h11);
    tick();
    rst = 1'b1; bus.in_valid = 4'b1111;
    settle();
    chk("mid_rst_in_ready", {28'd0, bus.in_ready}, 32'd0);
    tick();
    rst = 1'b0; bus.out_ready = 1'b1;
    sb.push_back('{d: 8'h10, c: 2'd0});
    settle();
    chk("post_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("post_rst_out_data", {24'd0, bus.out_data}, 32'd0);
    chk("post_rst_in_ready", {28'd0, bus.in_ready}, 32'h1);
    tick();
    bus.in_valid = 4'b0000;
    tick(); tick();
    settle();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mux_rr_pipe
